store_buffer: RTL

Posted-store FIFO between the EX/MEM pipeline register and the 1K-word data memory. It accepts sw/sh/sb stores from the pipeline and drains them to the memory write port in order, one per cycle, whenever the shared address port is not needed by a load. It also detects load-after-store hazards against pending entries and stalls the load, or optionally forwards the data. Byte-lane convention is big-endian: offset 00 is bits 31:24.

---
 rtl/store_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Posted-store FIFO between EX/MEM and the data memory write port, with
// load-after-store hazard detection. Define STORE_FWD_EN to forward full-word stores to lw.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        StoreValid,
  input  logic [31:0] StoreAddress,
  input  logic [31:0] StoreData,
  input  logic [1:0]  SControl,
  output logic        StoreReady,
  input  logic        LoadValid,
  input  logic [31:0] LoadAddress,
  input  logic [1:0]  LControl,
  output logic        LoadStall,
  output logic        FwdValid,
  output logic [31:0] FwdData,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic [1:0]  MemSControl,
  output logic        Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   addr_reg [DEPTH];
  logic [31:0]   data_reg [DEPTH];
  logic [1:0]    sctl_reg [DEPTH];

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [AW:0]   count_reg, count_next;

  logic          full;
  logic          push;
  logic          pop;
  logic          match;
  logic          fwd_ok;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_match;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign Empty      = (count_reg == '0);
  assign StoreReady = !full;
  assign push       = StoreValid && StoreReady;

  // An entry is live when its age relative to head is below count; the
  // subtraction wraps naturally because DEPTH is a power of two.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] age;
      assign age             = AW'(gi) - head_reg;
      assign entry_valid[gi] = ({1'b0, age} < count_reg);
      assign entry_match[gi] = entry_valid[gi] &&
                               (addr_reg[gi][31:2] == LoadAddress[31:2]);
    end
  endgenerate

  assign match = |entry_match;

`ifdef STORE_FWD_EN
  logic [AW-1:0] yng_idx;

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    yng_idx = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_match[head_reg + AW'(k)]) begin
        yng_idx = head_reg + AW'(k);
      end
    end
  end

  assign fwd_ok   = (LControl == 2'b00) && (sctl_reg[yng_idx] == 2'b00);
  assign FwdValid = LoadValid && !full && match && fwd_ok;
  assign FwdData  = FwdValid ? data_reg[yng_idx] : 32'd0;

  logic unused_lo;
  assign unused_lo = ^LoadAddress[1:0];
`else
  assign fwd_ok   = 1'b0;
  assign FwdValid = 1'b0;
  assign FwdData  = 32'd0;

  logic unused_lo;
  assign unused_lo = ^{LoadAddress[1:0], LControl};
`endif

  assign LoadStall = LoadValid && (full || (match && !fwd_ok));
  assign MemWrite  = !Empty && (!LoadValid || LoadStall);
  assign pop       = MemWrite;

  assign MemAddress   = Empty ? 32'd0 : addr_reg[head_reg];
  assign MemWriteData = Empty ? 32'd0 : data_reg[head_reg];
  assign MemSControl  = Empty ? 2'b00 : sctl_reg[head_reg];

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (push) begin
      tail_next = tail_reg + 1'b1;
    end
    if (pop) begin
      head_next = head_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Payload storage needs no reset: liveness comes from the pointers.
  always_ff @(posedge Clk) begin
    if (Rst && push) begin
      addr_reg[tail_reg] <= StoreAddress;
      data_reg[tail_reg] <= StoreData;
      sctl_reg[tail_reg] <= SControl;
    end
  end

endmodule
